wm_plant_sensor: RTL and testbench

//  Plant-side responder for the washing-machine controller FSM: consumes the controller's actuator

---
 rtl/wm_pkg.sv | 19 +
 rtl/wm_plant_sensor_if.sv | 35 +++
 rtl/wm_tick_timer.sv | 56 +++++
 rtl/wm_plant_sensor.sv | 101 ++++++++++
 tb/tb_wm_plant_sensor.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/wm_pkg.sv
// wm_pkg: shared constants and timer-state encoding for the wm plant model.
// Defaults for level/timer widths, fill/drain rates and tick counts.
package wm_pkg;

  localparam int LVL_W_D       = 8;
  localparam int TMR_W_D       = 16;
  localparam int FULL_LVL_D    = 200;
  localparam int FILL_RATE_D   = 4;
  localparam int DRAIN_RATE_D  = 8;
  localparam int CYCLE_TICKS_D = 1000;
  localparam int SPIN_TICKS_D  = 500;

  typedef logic [1:0] tmr_st_t;

  localparam tmr_st_t ST_IDLE = 2'd0;
  localparam tmr_st_t ST_RUN  = 2'd1;
  localparam tmr_st_t ST_FIRE = 2'd2;

endpackage

// File: rtl/wm_plant_sensor_if.sv
// wm_plant_sensor_if: controller <-> plant bundle.
// master = controller (drives commands), slave = plant (drives sensors).
interface wm_plant_sensor_if
  import wm_pkg::*;
#(
  parameter int LVL_W = LVL_W_D
);

  logic             fill_valve_on;
  logic             drain_valve_on;
  logic             motor_on;
  logic             door_lock;
  logic             water_wash;
  logic             water_filled;
  logic             drained;
  logic             cycle_timeout;
  logic             spin_timeout;
  logic [LVL_W-1:0] level;
  logic             fault;

  modport master (
    output fill_valve_on, drain_valve_on, motor_on,
    output door_lock, water_wash,
    input  water_filled, drained, cycle_timeout,
    input  spin_timeout, level, fault
  );

  modport slave (
    input  fill_valve_on, drain_valve_on, motor_on,
    input  door_lock, water_wash,
    output water_filled, drained, cycle_timeout,
    output spin_timeout, level, fault
  );

endinterface

// File: rtl/wm_tick_timer.sv
// wm_tick_timer: counts clks while i_en; registered 1-clk o_pulse
// after TICKS enabled clks. Ports: clk, reset(sync, low), i_en, o_pulse.
module wm_tick_timer
  import wm_pkg::*;
#(
  parameter int TMR_W = TMR_W_D,
  parameter int TICKS = CYCLE_TICKS_D
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_pulse
);

  tmr_st_t          r_state;
  logic [TMR_W-1:0] r_cnt;

  // IDLE->RUN consumes the first enabled clk, so the count starts at 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_en) begin
            r_state <= ST_RUN;
            r_cnt   <= TMR_W'(1);
          end
        end
        ST_RUN: begin
          if (!i_en) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == TMR_W'(TICKS - 1)) begin
            r_state <= ST_FIRE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + TMR_W'(1);
          end
        end
        ST_FIRE: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_pulse = (r_state == ST_FIRE);

endmodule

// File: rtl/wm_plant_sensor.sv
// wm_plant_sensor: water-level model, cycle/spin timers, fault flag.
// Ports: clk, reset (sync, active-low), bus (slave). Macro: WM_FAULT_DETECT_EN.
module wm_plant_sensor
  import wm_pkg::*;
#(
  parameter int LVL_W       = LVL_W_D,
  parameter int FULL_LVL    = FULL_LVL_D,
  parameter int FILL_RATE   = FILL_RATE_D,
  parameter int DRAIN_RATE  = DRAIN_RATE_D,
  parameter int TMR_W       = TMR_W_D,
  parameter int CYCLE_TICKS = CYCLE_TICKS_D,
  parameter int SPIN_TICKS  = SPIN_TICKS_D
) (
  input  logic               clk,
  input  logic               reset,
  wm_plant_sensor_if.slave   bus
);

  localparam int LW1 = LVL_W + 1;

  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_lvl_nxt;
  logic [LVL_W:0]   w_up;
  logic [LVL_W-1:0] w_up_sat;
  logic [LVL_W-1:0] w_dn_flr;
  logic             w_fill;
  logic             w_drain;
  logic             w_spin_en;

  assign w_fill  = bus.fill_valve_on & ~bus.drain_valve_on;
  assign w_drain = bus.drain_valve_on & ~bus.fill_valve_on;

  // Extra bit catches overflow so the level saturates instead of wrapping.
  assign w_up     = {1'b0, r_level} + LW1'(FILL_RATE);
  assign w_up_sat = w_up[LVL_W] ? '1 : w_up[LVL_W-1:0];
  assign w_dn_flr = ({1'b0, r_level} < LW1'(DRAIN_RATE)) ? '0
                  : r_level - LVL_W'(DRAIN_RATE);

  always_comb begin
    w_lvl_nxt = r_level;
    unique case (1'b1)
      w_fill:  w_lvl_nxt = w_up_sat;
      w_drain: w_lvl_nxt = w_dn_flr;
      default: w_lvl_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_level <= '0;
    else        r_level <= w_lvl_nxt;
  end

  assign bus.level        = r_level;
  assign bus.water_filled = (r_level >= LVL_W'(FULL_LVL));
  assign bus.drained      = (r_level == '0);

  assign w_spin_en = bus.drain_valve_on & bus.water_wash
                   & (r_level == '0);

  wm_tick_timer #(
    .TMR_W (TMR_W),
    .TICKS (CYCLE_TICKS)
  ) u_cycle (
    .clk     (clk),
    .reset   (reset),
    .i_en    (bus.motor_on),
    .o_pulse (bus.cycle_timeout)
  );

  wm_tick_timer #(
    .TMR_W (TMR_W),
    .TICKS (SPIN_TICKS)
  ) u_spin (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_spin_en),
    .o_pulse (bus.spin_timeout)
  );

`ifdef WM_FAULT_DETECT_EN
  logic r_fault;
  logic w_cause;

  // Any actuator with the door unlocked, or fill and drain fighting.
  assign w_cause = ((bus.fill_valve_on | bus.drain_valve_on
                   | bus.motor_on) & ~bus.door_lock)
                 | (bus.fill_valve_on & bus.drain_valve_on);

  always_ff @(posedge clk) begin
    if (!reset)       r_fault <= 1'b0;
    else if (w_cause) r_fault <= 1'b1;
  end

  assign bus.fault = r_fault;
`else
  logic w_unused_lock;
  assign w_unused_lock = bus.door_lock;
  assign bus.fault     = 1'b0;
`endif

endmodule

// File: tb/tb_wm_plant_sensor.sv
// tb_wm_plant_sensor: directed scoreboard bench for wm_plant_sensor.
// Stimulus pushes per-clk expectations; monitor pops after each edge.
module tb_wm_plant_sensor;
  import wm_pkg::*;

`ifdef WM_FAULT_DETECT_EN
  localparam logic FD = 1'b1;
`else
  localparam logic FD = 1'b0;
`endif

  typedef struct {
    string      nm;
    logic [7:0] lvl;
    logic       ct;
    logic       st;
    logic       ft;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  wm_plant_sensor_if bus ();

  wm_plant_sensor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cyc(
    input string      nm,
    input logic       rs, fl, dr, mo, lk, ww,
    input logic [7:0] lvl,
    input logic       ct, st, ft
  );
    exp_t e;
    @(negedge clk);
    reset              = rs;
    bus.fill_valve_on  = fl;
    bus.drain_valve_on = dr;
    bus.motor_on       = mo;
    bus.door_lock      = lk;
    bus.water_wash     = ww;
    e.nm  = nm;
    e.lvl = lvl;
    e.ct  = ct;
    e.st  = st;
    e.ft  = ft;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t        e;
    logic [12:0] act;
    logic [12:0] req;
    #1;
    if (q.size() > 0) begin
      e   = q.pop_front();
      req = {e.lvl, (e.lvl >= 8'd200), (e.lvl == 8'd0),
             e.ct, e.st, e.ft};
      act = {bus.level, bus.water_filled, bus.drained,
             bus.cycle_timeout, bus.spin_timeout, bus.fault};
      checks++;
      if (act !== req) begin
        failures++;
        $display("FAIL %s t=%0t got lvl=%0d wf/dr/ct/st/ft=%b want lvl=%0d wf/dr/ct/st/ft=%b",
                 e.nm, $time, act[12:5], act[4:0], req[12:5], req[4:0]);
      end
    end
  end

  initial begin
    bus.fill_valve_on  = 1'b0;
    bus.drain_valve_on = 1'b0;
    bus.motor_on       = 1'b0;
    bus.door_lock      = 1'b1;
    bus.water_wash     = 1'b0;

    // reset, fill to full, hold, drain to empty, floor
    for (int k = 0; k < 2; k++)
      cyc("reset", 0, 0, 0, 0, 1, 0, 8'd0, 0, 0, 0);
    for (int k = 1; k <= 50; k++)
      cyc("fill", 1, 1, 0, 0, 1, 0, 8'(4 * k), 0, 0, 0);
    for (int k = 0; k < 2; k++)
      cyc("hold", 1, 0, 0, 0, 1, 0, 8'd200, 0, 0, 0);
    for (int k = 1; k <= 27; k++)
      cyc("drain", 1, 0, 1, 0, 1, 0,
          (k >= 25) ? 8'd0 : 8'(200 - 8 * k), 0, 0, 0);

    // saturation at 255 and floor from a non-multiple
    for (int k = 1; k <= 66; k++)
      cyc("fill_sat", 1, 1, 0, 0, 1, 0,
          (4 * k > 255) ? 8'd255 : 8'(4 * k), 0, 0, 0);
    for (int k = 1; k <= 33; k++)
      cyc("drain_floor", 1, 0, 1, 0, 1, 0,
          (255 - 8 * k < 0) ? 8'd0 : 8'(255 - 8 * k), 0, 0, 0);

    // cycle timer: pulse at 1000, abort at 600, restart clean
    for (int k = 1; k <= 1001; k++)
      cyc("cycle", 1, 0, 0, 1, 1, 0, 8'd0, (k == 1000), 0, 0);
    cyc("cycle_off", 1, 0, 0, 0, 1, 0, 8'd0, 0, 0, 0);
    for (int k = 1; k <= 600; k++)
      cyc("cycle_part", 1, 0, 0, 1, 1, 0, 8'd0, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      cyc("cycle_abort", 1, 0, 0, 0, 1, 0, 8'd0, 0, 0, 0);
    for (int k = 1; k <= 1000; k++)
      cyc("cycle_restart", 1, 0, 0, 1, 1, 0, 8'd0, (k == 1000), 0, 0);
    cyc("cycle_off2", 1, 0, 0, 0, 1, 0, 8'd0, 0, 0, 0);

    // spin timer: 500, re-pulse 501 later, leave-phase clears
    for (int k = 1; k <= 1002; k++)
      cyc("spin", 1, 0, 1, 0, 1, 1, 8'd0, 0,
          (k == 500 || k == 1001), 0);
    cyc("spin_leave", 1, 0, 1, 0, 1, 0, 8'd0, 0, 0, 0);
    for (int k = 1; k <= 300; k++)
      cyc("spin_part", 1, 0, 1, 0, 1, 1, 8'd0, 0, 0, 0);
    cyc("spin_leave2", 1, 0, 1, 0, 1, 0, 8'd0, 0, 0, 0);
    for (int k = 1; k <= 500; k++)
      cyc("spin_restart", 1, 0, 1, 0, 1, 1, 8'd0, 0, (k == 500), 0);
    cyc("spin_off", 1, 0, 0, 0, 1, 0, 8'd0, 0, 0, 0);

    // reset mid-count: level 120, cycle count 700
    for (int k = 1; k <= 30; k++)
      cyc("pre_rst_fill", 1, 1, 0, 1, 1, 0, 8'(4 * k), 0, 0, 0);
    for (int k = 31; k <= 700; k++)
      cyc("pre_rst_run", 1, 0, 0, 1, 1, 0, 8'd120, 0, 0, 0);
    cyc("mid_rst", 0, 1, 0, 1, 1, 0, 8'd0, 0, 0, 0);
    for (int k = 1; k <= 1000; k++)
      cyc("post_rst", 1, 0, 0, 1, 1, 0, 8'd0, (k == 1000), 0, 0);
    cyc("post_rst_off", 1, 0, 0, 0, 1, 0, 8'd0, 0, 0, 0);

    // fault: unlocked motor, sticky, reset clears, fill+drain
    cyc("fault_set", 1, 0, 0, 1, 0, 0, 8'd0, 0, 0, FD);
    for (int k = 0; k < 3; k++)
      cyc("fault_sticky", 1, 0, 0, 0, 1, 0, 8'd0, 0, 0, FD);
    cyc("fault_clr", 0, 0, 0, 0, 1, 0, 8'd0, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      cyc("fault_fill", 1, 1, 0, 0, 1, 0, 8'(4 * k), 0, 0, 0);
    for (int k = 0; k < 2; k++)
      cyc("both_on", 1, 1, 1, 0, 1, 0, 8'd20, 0, 0, FD);
    cyc("end_rst", 0, 0, 0, 0, 1, 0, 8'd0, 0, 0, 0);

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain left=%0d want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
